// File: rtl/toggle_pulse_gen_if.sv
// Button-side signal bundle for toggle_pulse_gen: raw button and mode in,
// debounced level, T drive and press count out.
interface toggle_pulse_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             btn_in;
    logic             mode;
    logic             t_out;
    logic             btn_level;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        output btn_in,
        output mode,
        input  t_out,
        input  btn_level,
        input  press_cnt
    );

    modport slave (
        input  btn_in,
        input  mode,
        output t_out,
        output btn_level,
        output press_cnt
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Push-button front end for the t_ff stage: 2-flop synchronizer, debounce FSM,
// and a shaper producing one T pulse per press (mode=0) or the debounced level (mode=1).
module toggle_pulse_gen #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    toggle_pulse_gen_if.slave   bus
);
    localparam int unsigned DB_W = 8;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CNT - 1);
    localparam logic [DB_W-1:0] DB_SAT  = DB_W'(STABLE_CNT);
    localparam bit SINGLE = (STABLE_CNT == 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e           state_q;
    logic [DB_W-1:0]  cnt_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             btn_level_q;
    logic             t_out_q;
    logic [CNT_W-1:0] press_cnt_q;

    logic             press_ev_c;
    logic             release_ev_c;
    logic             level_d;
    logic [DB_W-1:0]  cnt_inc_c;

    // Edge events shared by the FSM, the level register and the shaper.
    always_comb begin
        press_ev_c   = 1'b0;
        release_ev_c = 1'b0;
        case (state_q)
            IDLE:         press_ev_c   = sync2_q && SINGLE;
            PRESS_WAIT:   press_ev_c   = sync2_q && (cnt_q == DB_LAST);
            PRESSED:      release_ev_c = !sync2_q && SINGLE;
            RELEASE_WAIT: release_ev_c = !sync2_q && (cnt_q == DB_LAST);
            default: ;
        endcase
        level_d   = press_ev_c ? 1'b1 : (release_ev_c ? 1'b0 : btn_level_q);
        cnt_inc_c = (cnt_q < DB_SAT) ? cnt_q + DB_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            btn_level_q <= 1'b0;
            t_out_q     <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sync1_q     <= bus.btn_in;
            sync2_q     <= sync1_q;
            btn_level_q <= level_d;
            t_out_q     <= bus.mode ? level_d : press_ev_c;
            if (press_ev_c) begin
                press_cnt_q <= press_cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        if (SINGLE) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= DB_W'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (press_ev_c) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_inc_c;
                    end
                end
                PRESSED: begin
                    if (!sync2_q) begin
                        if (SINGLE) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= DB_W'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (release_ev_c) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_inc_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.t_out     = t_out_q;
    assign bus.btn_level = btn_level_q;
    assign bus.press_cnt = press_cnt_q;
endmodule
